// File: rtl/vram_fill_if.sv
// Fill-engine bus bundle: command channel, memory-controller VRAM write port,
// GPU draw handshake and status.
//   master : command source / GPU side (drives cmd_*, gpu_ready)
//   slave  : the fill engine (drives cmd_ready, memc_*, sig_draw, busy, done)
interface vram_fill_if #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 16
);
   localparam int unsigned WIDTH_W    = 6;
   localparam int unsigned HEIGHT_W   = 7;
   localparam int unsigned RAM_ADDR_W = 16;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [ADDR_W-1:0]     cmd_base;
   logic [WIDTH_W-1:0]    cmd_width;
   logic [HEIGHT_W-1:0]   cmd_height;
   logic [ADDR_W-1:0]     cmd_stride;
   logic [DATA_W-1:0]     cmd_data;
   logic                  cmd_flush;

   logic                  memc_ram_enable;
   logic                  memc_ram_write;
   logic [RAM_ADDR_W-1:0] memc_ram_addr;
   logic [DATA_W-1:0]     memc_ram_data_w;

   logic                  gpu_ready;
   logic                  sig_draw;
   logic                  busy;
   logic                  done;

   modport master (
      output cmd_valid, cmd_base, cmd_width, cmd_height, cmd_stride, cmd_data, cmd_flush,
      output gpu_ready,
      input  cmd_ready, memc_ram_enable, memc_ram_write, memc_ram_addr, memc_ram_data_w,
      input  sig_draw, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_base, cmd_width, cmd_height, cmd_stride, cmd_data, cmd_flush,
      input  gpu_ready,
      output cmd_ready, memc_ram_enable, memc_ram_write, memc_ram_addr, memc_ram_data_w,
      output sig_draw, busy, done
   );
endinterface

// File: rtl/vram_fill_engine.sv
// Rectangle fill engine: takes one fill command at a time and writes the fill
// word into VRAM one word per cycle, row by row, only while the GPU is idle.
// Optionally raises a one-cycle GPU draw request once the last word is written.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : vram_fill_if.slave (command in, VRAM write port out,
//                gpu_ready in, sig_draw/busy/done out)
module vram_fill_engine #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   vram_fill_if.slave bus
);
   localparam int unsigned WIDTH_W    = 6;
   localparam int unsigned HEIGHT_W   = 7;
   localparam int unsigned RAM_ADDR_W = 16;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] DRAW = 2'd2;
   localparam logic [1:0] FIN  = 2'd3;

   typedef struct packed {
      logic [ADDR_W-1:0]   stride;
      logic [DATA_W-1:0]   data;
      logic [WIDTH_W-1:0]  width;
      logic [HEIGHT_W-1:0] height;
      logic                flush;
   } cmd_t;

   logic [1:0]          state, state_nxt;
   cmd_t                cmd_q, cmd_nxt;
   logic [ADDR_W-1:0]   addr_q, addr_nxt;
   logic [ADDR_W-1:0]   row_base_q, row_base_nxt;
   logic [WIDTH_W-1:0]  col_q, col_nxt;
   logic [HEIGHT_W-1:0] row_q, row_nxt;
   logic                ram_en_q, ram_en_nxt;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_nxt;
   logic [DATA_W-1:0]   ram_data_q, ram_data_nxt;
   logic                sig_draw_q, sig_draw_nxt;
   logic                done_q, done_nxt;
   logic                cmd_ready_q;
   logic                busy_q;
   logic                row_end;
   logic                last_word;

   // Position flags within the rectangle being filled
   assign row_end   = (col_q == cmd_q.width - WIDTH_W'(1));
   assign last_word = row_end && (row_q == cmd_q.height - HEIGHT_W'(1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state, counter and output decisions
   always_comb begin
      state_nxt    = state;
      cmd_nxt      = cmd_q;
      addr_nxt     = addr_q;
      row_base_nxt = row_base_q;
      col_nxt      = col_q;
      row_nxt      = row_q;
      ram_en_nxt   = 1'b0;
      ram_addr_nxt = ram_addr_q;
      ram_data_nxt = ram_data_q;
      sig_draw_nxt = 1'b0;
      done_nxt     = 1'b0;

      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               cmd_nxt.stride = bus.cmd_stride;
               cmd_nxt.data   = bus.cmd_data;
               cmd_nxt.width  = bus.cmd_width;
               cmd_nxt.height = bus.cmd_height;
               cmd_nxt.flush  = bus.cmd_flush;
               addr_nxt       = bus.cmd_base;
               row_base_nxt   = bus.cmd_base;
               col_nxt        = '0;
               row_nxt        = '0;
               // Empty rectangle skips straight to the tail of the command
               if (bus.cmd_width == '0 || bus.cmd_height == '0)
                  state_nxt = bus.cmd_flush ? DRAW : FIN;
               else
                  state_nxt = FILL;
            end
         end
         FILL: begin
            // GPU owns VRAM while busy: hold everything, no word lost
            if (bus.gpu_ready) begin
               ram_en_nxt   = 1'b1;
               ram_addr_nxt = addr_q;
               ram_data_nxt = cmd_q.data;
               if (!row_end) begin
                  col_nxt  = col_q + WIDTH_W'(1);
                  addr_nxt = addr_q + ADDR_W'(1);
               end else begin
                  col_nxt      = '0;
                  row_nxt      = row_q + HEIGHT_W'(1);
                  row_base_nxt = row_base_q + cmd_q.stride;
                  addr_nxt     = row_base_q + cmd_q.stride;
               end
               if (last_word)
                  state_nxt = cmd_q.flush ? DRAW : FIN;
            end
         end
         DRAW: begin
            if (bus.gpu_ready) begin
               sig_draw_nxt = 1'b1;
               state_nxt    = FIN;
            end
         end
         default: begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   // Registered datapath and outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q       <= '0;
         addr_q      <= '0;
         row_base_q  <= '0;
         col_q       <= '0;
         row_q       <= '0;
         ram_en_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_data_q  <= '0;
         sig_draw_q  <= 1'b0;
         done_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         cmd_q       <= cmd_nxt;
         addr_q      <= addr_nxt;
         row_base_q  <= row_base_nxt;
         col_q       <= col_nxt;
         row_q       <= row_nxt;
         ram_en_q    <= ram_en_nxt;
         ram_addr_q  <= ram_addr_nxt;
         ram_data_q  <= ram_data_nxt;
         sig_draw_q  <= sig_draw_nxt;
         done_q      <= done_nxt;
         cmd_ready_q <= (state_nxt == IDLE);
         busy_q      <= (state_nxt != IDLE);
      end
   end

   assign bus.cmd_ready       = cmd_ready_q;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.sig_draw        = sig_draw_q;
   assign bus.memc_ram_enable = ram_en_q;
   assign bus.memc_ram_write  = ram_en_q;
   assign bus.memc_ram_addr   = {{(RAM_ADDR_W-ADDR_W){1'b0}}, ram_addr_q};
   assign bus.memc_ram_data_w = ram_data_q;
endmodule

// File: tb/tb_vram_fill_engine.sv
// Bench for vram_fill_engine: directed cases plus randomized commands with a
// randomly stalling GPU, checked cycle by cycle against an event scoreboard.
module tb_vram_fill_engine;
   localparam int unsigned ADDR_W = 11;
   localparam int unsigned DATA_W = 16;
   localparam int EV_WR    = 0;
   localparam int EV_DRAW  = 1;
   localparam int EV_DONE  = 2;
   localparam int WAIT_MAX = 5000;

   typedef struct {
      int                kind;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;

   vram_fill_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   vram_fill_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int                tests = 0;
   int                fails = 0;
   int                cyc = 0;
   logic              gr_s = 1'b0;
   ev_t               sb[$];
   int                acc_edge = 0;
   logic              run_mon = 1'b0;
   logic              rnd_gr = 1'b0;
   int                st_from = -1;
   int                st_to = -1;
   logic [ADDR_W-1:0] last_a = '0;
   logic [DATA_W-1:0] last_d = '0;
   int                last_draw_edge = -1;
   int                last_done_edge = -1;
   int                draw_count = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", nm, act, want, cyc);
      end
   endtask

   // Edge counter and GPU_READY as sampled by the DUT on each edge
   always @(posedge clk) begin
      cyc  <= cyc + 1;
      gr_s <= bus.gpu_ready;
   end

   // GPU side: ready always, randomly, or forced low over an edge window
   always @(negedge clk) begin : gpu_drv
      logic nr;
      nr = rnd_gr ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (cyc + 1 >= st_from && cyc + 1 <= st_to) nr = 1'b0;
      bus.gpu_ready = nr;
   end

   // Monitor: every edge after an accept must show exactly the next event the
   // model allows (writes/draw need GPU ready on that edge, done does not)
   always @(negedge clk) begin : mon
      ev_t        e;
      logic [2:0] exp_v;
      logic [2:0] obs_v;
      if (!rst_n) begin
         sb.delete();
         last_a = '0;
         last_d = '0;
      end else if (run_mon) begin
         exp_v  = 3'b000;
         e.kind = EV_DONE;
         e.addr = '0;
         e.data = '0;
         if (sb.size() > 0 && cyc > acc_edge && (sb[0].kind == EV_DONE || gr_s)) begin
            e = sb.pop_front();
            case (e.kind)
               EV_WR:   exp_v = 3'b100;
               EV_DRAW: exp_v = 3'b010;
               default: exp_v = 3'b001;
            endcase
         end
         obs_v = {bus.memc_ram_enable, bus.sig_draw, bus.done};
         chk("event{en,draw,done}", 32'(obs_v), 32'(exp_v));
         chk("ram_write", 32'(bus.memc_ram_write), 32'(exp_v[2]));
         if (exp_v[2]) begin
            last_a = e.addr;
            last_d = e.data;
         end
         chk("ram_addr", 32'(bus.memc_ram_addr), 32'({5'b0, last_a}));
         chk("ram_data", 32'(bus.memc_ram_data_w), 32'(last_d));
         chk("cmd_ready", 32'(bus.cmd_ready), 32'(sb.size() == 0));
         chk("busy", 32'(bus.busy), 32'(sb.size() != 0));
         if (obs_v[1]) begin
            last_draw_edge = cyc;
            draw_count++;
         end
         if (obs_v[0]) last_done_edge = cyc;
      end
   end

   // Issue one command at the first cycle the engine is ready (garbage is
   // presented while it is busy) and push the expected events
   task automatic run_cmd(input int base, input int w, input int h, input int stride,
                          input logic [DATA_W-1:0] data, input logic flush);
      ev_t e;
      bit  ok;
      ok = 1'b0;
      for (int i = 0; i < WAIT_MAX && !ok; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin
            bus.cmd_base   = ADDR_W'(base);
            bus.cmd_width  = 6'(w);
            bus.cmd_height = 7'(h);
            bus.cmd_stride = ADDR_W'(stride);
            bus.cmd_data   = data;
            bus.cmd_flush  = flush;
            bus.cmd_valid  = 1'b1;
            @(posedge clk);
            #1;
            acc_edge = cyc;
            for (int r = 0; r < h; r++) begin
               for (int c = 0; c < w; c++) begin
                  e.kind = EV_WR;
                  e.addr = ADDR_W'((base + r * stride + c) % (1 << ADDR_W));
                  e.data = data;
                  sb.push_back(e);
               end
            end
            e.addr = '0;
            e.data = '0;
            if (flush) begin
               e.kind = EV_DRAW;
               sb.push_back(e);
            end
            e.kind = EV_DONE;
            sb.push_back(e);
            bus.cmd_valid = 1'b0;
            ok = 1'b1;
         end else begin
            bus.cmd_base   = ADDR_W'($urandom);
            bus.cmd_width  = 6'($urandom);
            bus.cmd_height = 7'($urandom);
            bus.cmd_stride = ADDR_W'($urandom);
            bus.cmd_data   = DATA_W'($urandom);
            bus.cmd_flush  = 1'($urandom);
            bus.cmd_valid  = 1'($urandom);
         end
      end
      chk("accept_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < WAIT_MAX && !idle; i++) begin
         @(negedge clk);
         #1;
         idle = (sb.size() == 0) && bus.cmd_ready;
      end
      chk("idle_timeout", 32'(idle), 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_sig_draw"}, 32'(bus.sig_draw), 32'd0);
      chk({tag, "_enable"}, 32'(bus.memc_ram_enable), 32'd0);
      chk({tag, "_write"}, 32'(bus.memc_ram_write), 32'd0);
      chk({tag, "_addr"}, 32'(bus.memc_ram_addr), 32'd0);
      chk({tag, "_data"}, 32'(bus.memc_ram_data_w), 32'd0);
   endtask

   // Directed case with edge offsets (from accept) of the draw and done pulses
   task automatic directed(input string nm, input int base, input int w, input int h,
                           input int stride, input logic [DATA_W-1:0] data, input logic flush,
                           input int st_lo, input int st_hi, input int draw_at, input int done_at);
      int d0;
      int a;
      d0 = draw_count;
      run_cmd(base, w, h, stride, data, flush);
      a = acc_edge;
      if (st_lo > 0) begin
         st_from = a + st_lo;
         st_to   = a + st_hi;
      end
      wait_idle();
      st_from = -1;
      st_to   = -1;
      chk({nm, "_done_cycle"}, 32'(last_done_edge - a), 32'(done_at));
      chk({nm, "_draw_count"}, 32'(draw_count - d0), 32'(flush));
      if (flush) chk({nm, "_draw_cycle"}, 32'(last_draw_edge - a), 32'(draw_at));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $finish;
   end

   initial begin : stim
      int a1;
      rst_n          = 1'b0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_base   = '0;
      bus.cmd_width  = '0;
      bus.cmd_height = '0;
      bus.cmd_stride = '0;
      bus.cmd_data   = '0;
      bus.cmd_flush  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      @(posedge clk);
      #2;
      rst_n   = 1'b1;
      run_mon = 1'b1;

      directed("basic", 'h010, 4, 2, 32, 16'hABCD, 1'b0, 0, 0, 0, 9);
      directed("wrap", 'h7FE, 4, 1, 9, 16'h1234, 1'b0, 0, 0, 0, 5);
      directed("stall", 'h100, 3, 1, 7, 16'h5A5A, 1'b0, 2, 4, 0, 7);
      directed("flush", 'h200, 2, 1, 5, 16'hC3C3, 1'b1, 3, 5, 6, 7);
      directed("zero_w", 'h055, 0, 5, 3, 16'h0F0F, 1'b1, 0, 0, 1, 2);
      directed("zero_h", 'h066, 7, 0, 3, 16'hF0F0, 1'b0, 0, 0, 0, 1);
      directed("max_w", 'h7C0, 63, 2, 100, 16'h1111, 1'b0, 0, 0, 0, 127);
      directed("max_h", 'h123, 1, 127, 16, 16'h2222, 1'b1, 0, 0, 128, 129);
      directed("overlap", 'h040, 5, 3, 2, 16'h3333, 1'b1, 0, 0, 16, 17);

      // Back-to-back: the next accept lands on the edge CMD_READY returns
      run_cmd('h080, 3, 1, 4, 16'h4444, 1'b0);
      a1 = acc_edge;
      run_cmd('h090, 2, 2, 8, 16'h5555, 1'b1);
      chk("b2b_accept", 32'(acc_edge - a1), 32'd5);
      wait_idle();

      // Asynchronous reset during the third word of a fill
      run_cmd('h300, 8, 1, 0, 16'h6666, 1'b1);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midreset");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_reset_ready", 32'(bus.cmd_ready), 32'd1);
      directed("after_reset", 'h310, 4, 2, 32, 16'h7777, 1'b1, 0, 0, 9, 10);

      // Randomized commands against a randomly stalling GPU
      rnd_gr = 1'b1;
      for (int n = 0; n < 40; n++) begin
         int w;
         int h;
         int sel;
         sel = int'($urandom_range(0, 7));
         case (sel)
            0: begin
               w = int'($urandom_range(0, 3));
               h = (w == 0) ? int'($urandom_range(0, 127)) : 0;
            end
            1: begin
               w = 63;
               h = int'($urandom_range(1, 2));
            end
            2: begin
               w = 1;
               h = int'($urandom_range(100, 127));
            end
            default: begin
               w = int'($urandom_range(1, 10));
               h = int'($urandom_range(1, 6));
            end
         endcase
         run_cmd(int'($urandom_range(0, 2047)), w, h, int'($urandom_range(0, 2047)),
                 DATA_W'($urandom), 1'($urandom_range(0, 1)));
      end
      wait_idle();
      rnd_gr = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
